alu_issue_regfile: RTL

//  32x32 register file plus issue/writeback controller that drives the ALU operand port and consumes its result.

---
 rtl/alu_issue_regfile_if.sv | 50 +++++
 rtl/alu_issue_regfile.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_regfile_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_issue_regfile_if                                          |
// | Purpose  : Bundles the instruction handshake, the ALU operand/result     |
// |            port, the completion status and the debug read port of        |
// |            alu_issue_regfile.                                            |
// | Modports : slave  - the issue/regfile controller                         |
// |            master - decoder/ALU/debug side (driver of the controller)    |
// | Signals  : in_valid/in_ready/in_rd/in_rs1/in_rs2/in_control/in_mux       |
// |            alu_a/alu_b/alu_control/alu_mux/alu_result/alu_zero           |
// |            done/done_zero/err_op, dbg_addr/dbg_data                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface alu_issue_regfile_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [3:0]      in_control;
    logic [1:0]      in_mux;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_control;
    logic [1:0]      alu_mux;
    logic [XLEN-1:0] alu_result;
    logic [1:0]      alu_zero;
    logic            done;
    logic            done_zero;
    logic            err_op;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_data;

    modport slave (
        input  in_valid, in_rd, in_rs1, in_rs2, in_control, in_mux,
        input  alu_result, alu_zero, dbg_addr,
        output in_ready, alu_a, alu_b, alu_control, alu_mux,
        output done, done_zero, err_op, dbg_data
    );

    modport master (
        output in_valid, in_rd, in_rs1, in_rs2, in_control, in_mux,
        output alu_result, alu_zero, dbg_addr,
        input  in_ready, alu_a, alu_b, alu_control, alu_mux,
        input  done, done_zero, err_op, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_issue_regfile                                             |
// | Purpose  : NREG x XLEN register file with an issue/writeback controller. |
// |            Accepts one ALU instruction per handshake, presents R[rs1],   |
// |            R[rs2], control and mux to the ALU, waits ALU_LAT cycles,     |
// |            captures result/zero and writes the result back to R[rd].     |
// | Ports    : clk     - system clock, rising edge                           |
// |            reset_n - synchronous active-low reset                        |
// |            bus     - alu_issue_regfile_if.slave (handshake, ALU port,    |
// |                      done/done_zero/err_op status, debug read port)      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_issue_regfile #(
    parameter int NREG    = 32,
    parameter int XLEN    = 32,
    parameter int ALU_LAT = 2
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    alu_issue_regfile_if.slave  bus
);
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_WB    = 2'd3;
    localparam logic [3:0] c_LAT_M1  = 4'(ALU_LAT - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            w_in_ready;
    logic            w_legal;

    logic [XLEN-1:0] r_regs [NREG];
    logic [4:0]      r_rd;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [3:0]      r_control;
    logic [1:0]      r_mux;
    logic [3:0]      r_cnt;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_err;

    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [3:0]      r_alu_control;
    logic [1:0]      r_alu_mux;
    logic            r_done;
    logic            r_done_zero;
    logic            r_err_op;

    // Only and/or/add/sub are implemented by the downstream ALU.
    always_comb begin
        w_legal = 1'b0;
        case (r_control)
            4'b0000, 4'b0001, 4'b0010, 4'b0110: w_legal = 1'b1;
            default:                            w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = c_S_ISSUE;
                end
            end
            // Illegal ops skip the ALU round trip and report straight away.
            c_S_ISSUE: w_state_nxt = w_legal ? c_S_WAIT : c_S_WB;
            c_S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_S_WB;
                end
            end
            c_S_WB:   w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_rd          <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_control     <= '0;
            r_mux         <= '0;
            r_cnt         <= '0;
            r_result      <= '0;
            r_zero        <= 1'b0;
            r_err         <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_control <= '0;
            r_alu_mux     <= '0;
            r_done        <= 1'b0;
            r_done_zero   <= 1'b0;
            r_err_op      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_done_zero <= 1'b0;
            r_err_op    <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (bus.in_valid) begin
                        r_rd      <= bus.in_rd;
                        r_rs1     <= bus.in_rs1;
                        r_rs2     <= bus.in_rs2;
                        r_control <= bus.in_control;
                        r_mux     <= bus.in_mux;
                    end
                end
                c_S_ISSUE: begin
                    r_err <= ~w_legal;
                    r_cnt <= c_LAT_M1;
                    // ALU outputs keep their previous values on an illegal op.
                    if (w_legal) begin
                        r_alu_a       <= r_regs[r_rs1];
                        r_alu_b       <= r_regs[r_rs2];
                        r_alu_control <= r_control;
                        r_alu_mux     <= r_mux;
                    end
                end
                c_S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_result <= bus.alu_result;
                        r_zero   <= |bus.alu_zero;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_S_WB: begin
                    r_done      <= 1'b1;
                    r_err_op    <= r_err;
                    // r_zero is stale on an aborted op, so it is masked.
                    r_done_zero <= r_zero & ~r_err;
                    if (!r_err && (r_rd != 5'd0)) begin
                        r_regs[r_rd] <= r_result;
                    end
                end
                default: begin
                    r_err <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_control = r_alu_control;
    assign bus.alu_mux     = r_alu_mux;
    assign bus.done        = r_done;
    assign bus.done_zero   = r_done_zero;
    assign bus.err_op      = r_err_op;
    assign bus.dbg_data    = (bus.dbg_addr == 5'd0) ? '0 : r_regs[bus.dbg_addr];
endmodule
`default_nettype wire
